sram_controller: RTL

Synchronous master for the asynchronous 64Kx8 RAM interface: active-low enable and write strobes, separate input and output data buses. It converts a one-cycle request pulse on the system clock into a fully timed RAM read or write. Address and data setup, strobe width and hold are all generated from clock cycles. It sits between the CPU/bus logic and the RAM instance and is the only driver of the RAM's address, strobes and write data.

---
 rtl/sram_controller.sv | 118 +++++++++++
 1 files changed

// File: rtl/sram_controller.sv
// Timed master for an asynchronous 64Kx8 RAM: turns a one-cycle request into strobe/address/data sequencing.
// Latency: request at edge N -> o_ack high in the cycle after edge N+1+WAIT_CYCLES; one access per WAIT_CYCLES+3 cycles.
// Backpressure: o_busy high from acceptance through the ack cycle; requests seen while busy are dropped, never queued.
module sram_controller #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic                  o_busy,
  output logic                  o_ack,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic                  o_ram_enable_x,
  output logic                  o_ram_write_x,
  output logic [DATA_WIDTH-1:0] o_ram_data,
  input  logic [DATA_WIDTH-1:0] i_ram_data
);

  // Strobe width is clamped to 1..255 so the 8-bit counter can always hold the load value.
  localparam int WAIT_EFF = (WAIT_CYCLES < 1) ? 1 : ((WAIT_CYCLES > 255) ? 255 : WAIT_CYCLES);
  localparam logic [7:0] WAIT_LOAD = 8'(WAIT_EFF - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    ACCESS  = 2'd2,
    RECOVER = 2'd3
  } state_t;

  state_t                state_q;
  logic [7:0]            cnt_q;
  logic                  we_q;
  logic                  busy_q;
  logic                  ack_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [ADDR_WIDTH-1:0] ram_addr_q;
  logic                  ram_enable_x_q;
  logic                  ram_write_x_q;
  logic [DATA_WIDTH-1:0] ram_data_q;

  // Access sequencer: every RAM-facing signal is a register so strobe edges never glitch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= 8'd0;
      we_q           <= 1'b0;
      busy_q         <= 1'b0;
      ack_q          <= 1'b0;
      rdata_q        <= '0;
      ram_addr_q     <= '0;
      ram_enable_x_q <= 1'b1;
      ram_write_x_q  <= 1'b1;
      ram_data_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          ack_q <= 1'b0;
          if (i_req) begin
            we_q           <= i_we;
            ram_addr_q     <= i_addr;
            // Reads leave the write bus at its last value.
            if (i_we) begin
              ram_data_q <= i_wdata;
            end
            ram_enable_x_q <= 1'b0;
            busy_q         <= 1'b1;
            state_q        <= SETUP;
          end
        end
        SETUP: begin
          // Address has had a full cycle of setup before write_x falls.
          cnt_q <= WAIT_LOAD;
          if (we_q) begin
            ram_write_x_q <= 1'b0;
          end
          state_q <= ACCESS;
        end
        ACCESS: begin
          if (cnt_q == 8'd0) begin
            if (!we_q) begin
              rdata_q <= i_ram_data;
            end
            // Address and data stay put, giving hold time past the strobe rise.
            ram_enable_x_q <= 1'b1;
            ram_write_x_q  <= 1'b1;
            ack_q          <= 1'b1;
            state_q        <= RECOVER;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        RECOVER: begin
          ack_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign o_busy         = busy_q;
  assign o_ack          = ack_q;
  assign o_rdata        = rdata_q;
  assign o_ram_addr     = ram_addr_q;
  assign o_ram_enable_x = ram_enable_x_q;
  assign o_ram_write_x  = ram_write_x_q;
  assign o_ram_data     = ram_data_q;

endmodule
